// File: rtl/spike_detector.sv
// spike_detector
// ---------------------------------------------------------------------------
// Detection stage after the band-pass cascade. It tracks an adaptive noise
// floor as a leaky average of |x|. A spike starts on the first sample whose
// magnitude exceeds a scaled floor. For each spike the block reports one pulse,
// the signed peak sample and the timestamp of the first above-threshold sample.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   x_in       filtered sample, signed DATA_W
//   x_valid    x_in carries a new sample this cycle
//   spike      one-cycle pulse when a spike has closed
//   spike_peak signed sample of largest magnitude in the last spike
//   spike_ts   timestamp of the first above-threshold sample of the last spike
//   thr_out    threshold that applies to the next sample, unsigned DATA_W-1
//   armed      high while the detector is armed
// ---------------------------------------------------------------------------
module spike_detector #(
  parameter int DATA_W    = 11,
  parameter int AVG_SHIFT = 6,
  parameter int THR_MULT  = 4,
  parameter int THR_MIN   = 16,
  parameter int WARMUP    = 64,
  parameter int REFRACT   = 32,
  parameter int MAX_LEN   = 64,
  parameter int TS_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  output logic                     spike,
  output logic signed [DATA_W-1:0] spike_peak,
  output logic [TS_W-1:0]          spike_ts,
  output logic [DATA_W-2:0]        thr_out,
  output logic                     armed
);

  localparam int MW  = DATA_W - 1;          // magnitude width
  localparam int AW  = MW + AVG_SHIFT;      // noise-floor accumulator width
  localparam int PW  = MW + 3;              // mean * THR_MULT (THR_MULT <= 7)
  localparam int WCW = $clog2(WARMUP + 1);
  localparam int RCW = $clog2(REFRACT + 1);
  localparam int LW  = $clog2(MAX_LEN + 1);

  localparam logic [MW-1:0]            MAG_MAX = {MW{1'b1}};
  localparam logic signed [DATA_W-1:0] MIN_V   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_ARMED    = 2'd1,
    ST_IN_SPIKE = 2'd2,
    ST_REFRACT  = 2'd3
  } state_t;

  // Saturating absolute value: the most negative code maps to the largest magnitude.
  function automatic logic [MW-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
    if (v == MIN_V) begin
      abs_sat = MAG_MAX;
    end else if (v[DATA_W-1]) begin
      abs_sat = MW'(-v);
    end else begin
      abs_sat = MW'(v);
    end
  endfunction

  // Threshold from the floor mean: max(mean*THR_MULT, THR_MIN), saturated to MW bits.
  function automatic logic [MW-1:0] calc_thr(input logic [MW-1:0] mean);
    logic [PW-1:0] prod;
    prod = PW'(mean) * PW'(THR_MULT);
    if (prod < PW'(THR_MIN)) begin
      prod = PW'(THR_MIN);
    end else begin
      prod = prod;
    end
    if (prod > PW'(MAG_MAX)) begin
      calc_thr = MAG_MAX;
    end else begin
      calc_thr = MW'(prod);
    end
  endfunction

  state_t                     state_r, state_nxt_s;
  logic [AW-1:0]              acc_r, acc_nxt_s;
  logic [TS_W-1:0]            ts_r;
  logic [WCW-1:0]             wcnt_r;
  logic [RCW-1:0]             rcnt_r;
  logic [LW-1:0]              len_r;
  logic [MW-1:0]              thr_l_r;
  logic signed [DATA_W-1:0]   pk_r;
  logic [MW-1:0]              pk_mag_r;
  logic [TS_W-1:0]            pk_ts_r;

  logic [MW-1:0]              mag_s;
  logic [MW-1:0]              thr_s;
  logic                       trigger_s;
  logic                       spike_end_s;
  logic                       spike_nxt_s;
  logic                       armed_nxt_s;

  assign mag_s = abs_sat(x_in);
  // Threshold seen by the current sample comes from the floor before this sample.
  assign thr_s = calc_thr(acc_r[AW-1:AVG_SHIFT]);

  // Leaky average; the arithmetic cannot wrap because acc - acc>>AVG_SHIFT + mag <= 2^AW-1.
  assign acc_nxt_s = acc_r - {{AVG_SHIFT{1'b0}}, acc_r[AW-1:AVG_SHIFT]}
                           + {{AVG_SHIFT{1'b0}}, mag_s};

  // Decode trigger and end-of-spike conditions for the current sample.
  always_comb begin
    trigger_s   = 1'b0;
    spike_end_s = 1'b0;
    if (x_valid && (state_r == ST_ARMED) && (mag_s > thr_s)) begin
      trigger_s = 1'b1;
    end else begin
      trigger_s = 1'b0;
    end
    // A sample at or below the latched threshold, or a spike at full length, closes it.
    if ((mag_s <= thr_l_r) || (len_r == LW'(MAX_LEN))) begin
      spike_end_s = 1'b1;
    end else begin
      spike_end_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_WARMUP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; nothing moves without a valid sample.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WARMUP: begin
        if (x_valid && (wcnt_r == WCW'(WARMUP - 1))) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_ARMED: begin
        if (trigger_s) begin
          state_nxt_s = ST_IN_SPIKE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_IN_SPIKE: begin
        if (x_valid && spike_end_s) begin
          state_nxt_s = ST_REFRACT;
        end else begin
          state_nxt_s = ST_IN_SPIKE;
        end
      end
      ST_REFRACT: begin
        // The sample that takes the counter to zero is itself not evaluated.
        if (x_valid && (rcnt_r == RCW'(1))) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_REFRACT;
        end
      end
      default: begin
        state_nxt_s = ST_WARMUP;
      end
    endcase
  end

  // Output decode feeding the registered outputs.
  always_comb begin
    spike_nxt_s = 1'b0;
    armed_nxt_s = 1'b0;
    if (x_valid && (state_r == ST_IN_SPIKE) && spike_end_s) begin
      spike_nxt_s = 1'b1;
    end else begin
      spike_nxt_s = 1'b0;
    end
    armed_nxt_s = (state_nxt_s == ST_ARMED);
  end

  // Noise floor, timestamp and published threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= AW'(0);
      ts_r    <= TS_W'(0);
      thr_out <= MW'(0);
    end else if (x_valid) begin
      ts_r <= ts_r + TS_W'(1);
      // Spike samples are kept out of the floor so a burst cannot raise its own threshold.
      if (state_r != ST_IN_SPIKE) begin
        acc_r   <= acc_nxt_s;
        thr_out <= calc_thr(acc_nxt_s[AW-1:AVG_SHIFT]);
      end else begin
        acc_r   <= acc_r;
        thr_out <= thr_out;
      end
    end else begin
      acc_r   <= acc_r;
      ts_r    <= ts_r;
      thr_out <= thr_out;
    end
  end

  // Warm-up and refractory counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r <= WCW'(0);
      rcnt_r <= RCW'(0);
    end else if (x_valid) begin
      if (state_r == ST_WARMUP) begin
        wcnt_r <= wcnt_r + WCW'(1);
      end else begin
        wcnt_r <= wcnt_r;
      end
      if ((state_r == ST_IN_SPIKE) && spike_end_s) begin
        rcnt_r <= RCW'(REFRACT);
      end else if (state_r == ST_REFRACT) begin
        rcnt_r <= rcnt_r - RCW'(1);
      end else begin
        rcnt_r <= rcnt_r;
      end
    end else begin
      wcnt_r <= wcnt_r;
      rcnt_r <= rcnt_r;
    end
  end

  // Per-spike tracking: latched threshold, length and running peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_l_r  <= MW'(0);
      len_r    <= LW'(0);
      pk_r     <= DATA_W'(0);
      pk_mag_r <= MW'(0);
      pk_ts_r  <= TS_W'(0);
    end else if (trigger_s) begin
      thr_l_r  <= thr_s;
      len_r    <= LW'(1);
      pk_r     <= x_in;
      pk_mag_r <= mag_s;
      pk_ts_r  <= ts_r;
    end else if (x_valid && (state_r == ST_IN_SPIKE) && !spike_end_s) begin
      len_r <= len_r + LW'(1);
      // Strict compare keeps the earliest sample on a magnitude tie.
      if (mag_s > pk_mag_r) begin
        pk_r     <= x_in;
        pk_mag_r <= mag_s;
      end else begin
        pk_r     <= pk_r;
        pk_mag_r <= pk_mag_r;
      end
    end else begin
      thr_l_r  <= thr_l_r;
      len_r    <= len_r;
      pk_r     <= pk_r;
      pk_mag_r <= pk_mag_r;
      pk_ts_r  <= pk_ts_r;
    end
  end

  // Registered spike report and armed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike      <= 1'b0;
      spike_peak <= DATA_W'(0);
      spike_ts   <= TS_W'(0);
      armed      <= 1'b0;
    end else begin
      spike <= spike_nxt_s;
      armed <= armed_nxt_s;
      if (spike_nxt_s) begin
        spike_peak <= pk_r;
        spike_ts   <= pk_ts_r;
      end else begin
        spike_peak <= spike_peak;
        spike_ts   <= spike_ts;
      end
    end
  end

endmodule

// File: tb/tb_spike_detector.sv
// Self-checking bench for spike_detector: directed streams, a behavioural
// model compared on every clock, and hand-computed literal expectations.
module tb_spike_detector;

  localparam int WARM  = 64;
  localparam int REFR  = 32;
  localparam int MAXL  = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               x_valid = 1'b0;
  logic signed [10:0] x_in = 11'sd0;
  logic               spike;
  logic signed [10:0] spike_peak;
  logic [15:0]        spike_ts;
  logic [9:0]         thr_out;
  logic               armed;

  int errors = 0;
  int checks = 0;
  int n_spk  = 0;
  bit chk_en = 1'b0;

  // model state: 0 warmup, 1 armed, 2 in spike, 3 refractory
  int m_state, m_cnt, m_acc, m_ts, m_thr_l, m_pk, m_pkmag, m_pkts, m_len;
  int e_spike, e_peak, e_ts, e_thr, e_armed;

  spike_detector dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .spike     (spike),
    .spike_peak(spike_peak),
    .spike_ts  (spike_ts),
    .thr_out   (thr_out),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int thr_of(input int acc);
    int p;
    p = (acc / 64) * 4;
    if (p < 16) p = 16;
    if (p > 1023) p = 1023;
    return p;
  endfunction

  task automatic model_step(input bit r, input int x, input bit v);
    int mag, thr;
    bit was_spike;
    if (r) begin
      m_state = 0; m_cnt = 0; m_acc = 0; m_ts = 0; m_thr_l = 0;
      m_pk = 0; m_pkmag = 0; m_pkts = 0; m_len = 0;
      e_spike = 0; e_peak = 0; e_ts = 0; e_thr = 0; e_armed = 0;
      return;
    end
    e_spike = 0;
    if (!v) return;
    mag = (x < 0) ? ((x == -1024) ? 1023 : -x) : x;
    thr = thr_of(m_acc);
    was_spike = (m_state == 2);
    case (m_state)
      0: begin
        m_cnt++;
        if (m_cnt == WARM) m_state = 1;
      end
      1: begin
        if (mag > thr) begin
          m_state = 2; m_thr_l = thr; m_pk = x; m_pkmag = mag; m_pkts = m_ts; m_len = 1;
        end
      end
      2: begin
        if (mag <= m_thr_l || m_len == MAXL) begin
          e_spike = 1; e_peak = m_pk; e_ts = m_pkts; m_state = 3; m_cnt = REFR;
        end else begin
          if (mag > m_pkmag) begin m_pk = x; m_pkmag = mag; end
          m_len++;
        end
      end
      default: begin
        m_cnt--;
        if (m_cnt == 0) m_state = 1;
      end
    endcase
    if (!was_spike) begin
      m_acc = m_acc + mag - (m_acc / 64);
      e_thr = thr_of(m_acc);
    end
    m_ts = (m_ts + 1) % 65536;
    e_armed = (m_state == 1) ? 1 : 0;
  endtask

  // Drive one clock worth of inputs, then advance the model with what was sampled.
  task automatic step(input bit r, input int x, input bit v);
    logic [31:0] xb;
    xb = x;
    rst = r; x_in = xb[10:0]; x_valid = v;
    @(posedge clk);
    model_step(r, x, v);
    #1;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    n_spk = 0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("spike", spike, e_spike);
      check("spike_peak", spike_peak, e_peak);
      check("spike_ts", spike_ts, e_ts);
      check("thr_out", thr_out, e_thr);
      check("armed", armed, e_armed);
      if (spike === 1'b1) n_spk++;
    end
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_armed", armed, 0);
    check("reset_thr", thr_out, 0);

    // Threshold floor: 16 does not trigger, 17 does.
    zeros(WARM);
    step(1'b0, 16, 1'b1);
    zeros(5);
    check("floor_no_spike", n_spk, 0);
    check("floor_thr", thr_out, 16);
    step(1'b0, 17, 1'b1);
    step(1'b0, 0, 1'b1);
    zeros(2);
    check("floor_count", n_spk, 1);
    check("floor_peak", spike_peak, 17);
    check("floor_ts", spike_ts, 70);
    check("floor_thr_after", thr_out, 16);

    // Peak capture and tie, then refractory.
    do_reset();
    zeros(WARM);
    step(1'b0, 50, 1'b1);
    step(1'b0, 120, 1'b1);
    step(1'b0, -120, 1'b1);
    step(1'b0, -90, 1'b1);
    step(1'b0, 0, 1'b1);
    zeros(1);
    check("peak_count", n_spk, 1);
    check("peak_value", spike_peak, 120);
    check("peak_ts", spike_ts, 64);
    check("peak_thr", thr_out, 16);
    zeros(10);                     // ts 70..79
    step(1'b0, 200, 1'b1);         // ts 80, refractory
    zeros(20);                     // ts 81..100
    check("refract_ignored", n_spk, 1);
    step(1'b0, 200, 1'b1);         // ts 101
    step(1'b0, 0, 1'b1);
    zeros(1);
    check("refract_count", n_spk, 2);
    check("refract_ts", spike_ts, 101);
    check("refract_peak", spike_peak, 200);

    // Warm-up: large sample ignored, armed only after 64 samples.
    do_reset();
    zeros(10);
    step(1'b0, 500, 1'b1);
    zeros(WARM - 12);
    check("warm_not_armed", armed, 0);
    zeros(1);
    check("warm_armed", armed, 1);
    zeros(5);
    check("warm_no_spike", n_spk, 0);

    // Saturation and forced end at maximum length.
    do_reset();
    zeros(WARM);
    for (int i = 0; i < 100; i++) step(1'b0, -1024, 1'b1);
    zeros(40);
    check("sat_count", n_spk, 1);
    check("sat_peak", spike_peak, -1024);
    check("sat_ts", spike_ts, 64);

    // x_valid gaps: same stream, same result.
    do_reset();
    for (int i = 0; i < WARM; i++) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 300, 1'b0);
    end
    step(1'b0, 50, 1'b1);   step(1'b0, 300, 1'b0);
    step(1'b0, 120, 1'b1);  step(1'b0, -700, 1'b0);
    step(1'b0, -120, 1'b1); step(1'b0, 300, 1'b0);
    step(1'b0, -90, 1'b1);  step(1'b0, 300, 1'b0);
    step(1'b0, 0, 1'b1);    step(1'b0, 300, 1'b0);
    zeros(1);
    check("gap_count", n_spk, 1);
    check("gap_peak", spike_peak, 120);
    check("gap_ts", spike_ts, 64);

    // Reset mid-spike discards the spike.
    do_reset();
    zeros(WARM);
    step(1'b0, 50, 1'b1);
    step(1'b0, 120, 1'b1);
    step(1'b1, -120, 1'b1);
    check("rst_peak", spike_peak, 0);
    check("rst_ts", spike_ts, 0);
    check("rst_armed", armed, 0);
    check("rst_spike", spike, 0);
    zeros(10);
    check("rst_no_pulse", n_spk, 0);
    check("rst_still_warm", armed, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
